password_lock_ctrl: RTL and testbench

Parametrised password entry, commit and check controller, and the successor of the fixed 4-digit password phase. It takes debounced single-cycle button pulses and builds an N-digit, radix-R code with a cursor. It converts the code to binary with a multi-cycle Horner loop. In set mode it commits the result as the board password; in check mode it compares against a reference and enforces an attempt limit with a timed lockout. Its outputs drive the 7-segment/OLED display logic and the game-state controller.

---
 rtl/password_lock_ctrl_pkg.sv | 47 ++++
 rtl/password_lock_ctrl_digits_to_binary.sv | 52 +++++
 rtl/password_lock_ctrl.sv | 149 ++++++++++++++
 tb/tb_password_lock_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/password_lock_ctrl_pkg.sv
// Shared encodings and helpers for the password entry/commit/check controller.
// State and mode codes match the values the display and game-state logic decode.
package password_lock_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_EDIT    = 3'd0,
    ST_CONVERT = 3'd1,
    ST_RESULT  = 3'd2,
    ST_LOCKED  = 3'd3
  } state_t;

  typedef enum logic {
    MODE_SET   = 1'b0,
    MODE_CHECK = 1'b1
  } mode_t;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_SUBMIT,
    ACT_INC,
    ACT_DEC,
    ACT_LEFT,
    ACT_RIGHT
  } action_t;

  localparam int DIGIT_W = 4;

  // One action per cycle; coincident pulses resolve C > U > D > L > R.
  function automatic action_t decode_action(input logic c, input logic u, input logic d,
                                            input logic l, input logic r);
    if (c) return ACT_SUBMIT;
    if (u) return ACT_INC;
    if (d) return ACT_DEC;
    if (l) return ACT_LEFT;
    if (r) return ACT_RIGHT;
    return ACT_NONE;
  endfunction

  function automatic logic [DIGIT_W-1:0] digit_step(input logic [DIGIT_W-1:0] d,
                                                    input logic up, input int radix);
    logic [DIGIT_W-1:0] last;
    last = DIGIT_W'(radix - 1);
    if (up) return (d == last) ? '0 : d + 1'b1;
    return (d == '0) ? last : d - 1'b1;
  endfunction

endpackage

// File: rtl/password_lock_ctrl_digits_to_binary.sv
// Horner-loop converter: most significant digit first, one digit per cycle.
// acc shows the value after the current step so the caller can capture it on done.
module password_lock_ctrl_digits_to_binary
  import password_lock_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int RADIX      = 10,
  parameter int PW_WIDTH   = 14
) (
  input  logic                          basys_clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] digits,
  output logic [PW_WIDTH+3:0]           acc,
  output logic                          done
);

  localparam int ACC_W = PW_WIDTH + 4;
  localparam int IW    = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0]    LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [ACC_W-1:0] RADIX_W  = ACC_W'(RADIX);

  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   acc_step;
  logic [IW-1:0]      idx_q;
  logic               busy_q;
  logic [DIGIT_W-1:0] cur_digit;

  assign cur_digit = digits[{idx_q, 2'b00} +: DIGIT_W];
  assign acc_step  = acc_q * RADIX_W + ACC_W'(cur_digit);
  assign acc       = busy_q ? acc_step : acc_q;
  assign done      = busy_q && (idx_q == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge basys_clk or posedge reset) begin
    if (reset) begin
      acc_q  <= '0;
      idx_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      acc_q  <= '0;
      idx_q  <= LAST_IDX;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      acc_q <= acc_step;
      if (idx_q == '0) busy_q <= 1'b0;
      else             idx_q  <= idx_q - 1'b1;
    end
  end

endmodule

// File: rtl/password_lock_ctrl.sv
// Password entry controller: digit/cursor editing, submit-and-convert, commit or
// check against a reference with an attempt limit and a timed lockout.
module password_lock_ctrl
  import password_lock_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int RADIX        = 10,
  parameter int PW_WIDTH     = 14,
  parameter int MAX_ATTEMPTS = 3,
  parameter int LOCK_CYCLES  = 100_000_000
) (
  input  logic                           basys_clk,
  input  logic                           reset,
  input  logic                           mode,
  input  logic                           btn_l,
  input  logic                           btn_r,
  input  logic                           btn_u,
  input  logic                           btn_d,
  input  logic                           btn_c,
  input  logic [PW_WIDTH-1:0]            ref_password,
  output logic [4*NUM_DIGITS-1:0]        digits,
  output logic [$clog2(NUM_DIGITS)-1:0]  cursor,
  output logic [PW_WIDTH-1:0]            entered_value,
  output logic [PW_WIDTH-1:0]            stored_password,
  output logic [2:0]                     state,
  output logic                           commit_pulse,
  output logic                           match_pulse,
  output logic                           fail_pulse,
  output logic                           locked,
  output logic [3:0]                     attempts_left
);

  localparam int CW    = $clog2(NUM_DIGITS);
  localparam int ACC_W = PW_WIDTH + 4;
  localparam int LW    = $clog2(LOCK_CYCLES + 1);
  localparam logic [CW-1:0] LAST_CUR  = CW'(NUM_DIGITS - 1);
  localparam logic [3:0]    MAX_ATT   = 4'(MAX_ATTEMPTS);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);

  state_t             state_q;
  mode_t              mode_q;
  logic [LW-1:0]      lock_cnt;
  action_t            action;
  logic [CW+1:0]      cur_sel;
  logic [DIGIT_W-1:0] cur_digit;
  logic               conv_start;
  logic               conv_done;
  logic [ACC_W-1:0]   conv_acc;
  logic [PW_WIDTH-1:0] conv_value;
  logic               unused_acc_hi;

  assign action     = decode_action(btn_c, btn_u, btn_d, btn_l, btn_r);
  assign cur_sel    = {cursor, 2'b00};
  assign cur_digit  = digits[cur_sel +: DIGIT_W];
  assign conv_start = (state_q == ST_EDIT) && (action == ACT_SUBMIT);
  assign conv_value = conv_acc[PW_WIDTH-1:0];
  assign unused_acc_hi = ^conv_acc[ACC_W-1:PW_WIDTH];
  assign state      = state_q;

  password_lock_ctrl_digits_to_binary #(
    .NUM_DIGITS (NUM_DIGITS),
    .RADIX      (RADIX),
    .PW_WIDTH   (PW_WIDTH)
  ) u_digits_to_binary (
    .basys_clk (basys_clk),
    .reset     (reset),
    .start     (conv_start),
    .digits    (digits),
    .acc       (conv_acc),
    .done      (conv_done)
  );

  // The result is decided on the last CONVERT edge so that the RESULT cycle
  // already shows the strobe together with its updated values.
  always_ff @(posedge basys_clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_EDIT;
      mode_q          <= MODE_SET;
      digits          <= '0;
      cursor          <= '0;
      entered_value   <= '0;
      stored_password <= '0;
      attempts_left   <= MAX_ATT;
      commit_pulse    <= 1'b0;
      match_pulse     <= 1'b0;
      fail_pulse      <= 1'b0;
      locked          <= 1'b0;
      lock_cnt        <= '0;
    end else begin
      commit_pulse <= 1'b0;
      match_pulse  <= 1'b0;
      fail_pulse   <= 1'b0;
      unique case (state_q)
        ST_EDIT: begin
          unique case (action)
            ACT_SUBMIT: begin
              mode_q  <= mode_t'(mode);
              state_q <= ST_CONVERT;
            end
            ACT_INC:   digits[cur_sel +: DIGIT_W] <= digit_step(cur_digit, 1'b1, RADIX);
            ACT_DEC:   digits[cur_sel +: DIGIT_W] <= digit_step(cur_digit, 1'b0, RADIX);
            ACT_LEFT:  cursor <= (cursor == LAST_CUR) ? '0 : cursor + 1'b1;
            ACT_RIGHT: cursor <= (cursor == '0) ? LAST_CUR : cursor - 1'b1;
            default: ;
          endcase
        end
        ST_CONVERT: begin
          if (conv_done) begin
            entered_value <= conv_value;
            state_q       <= ST_RESULT;
            if (mode_q == MODE_SET) begin
              stored_password <= conv_value;
              commit_pulse    <= 1'b1;
              attempts_left   <= MAX_ATT;
            end else if (conv_value == ref_password) begin
              match_pulse   <= 1'b1;
              attempts_left <= MAX_ATT;
              digits        <= '0;
            end else begin
              fail_pulse    <= 1'b1;
              attempts_left <= attempts_left - 1'b1;
              digits        <= '0;
            end
          end
        end
        ST_RESULT: begin
          if (attempts_left == '0) begin
            state_q  <= ST_LOCKED;
            locked   <= 1'b1;
            lock_cnt <= LOCK_LAST;
          end else begin
            state_q <= ST_EDIT;
          end
        end
        ST_LOCKED: begin
          if (lock_cnt == '0) begin
            locked        <= 1'b0;
            attempts_left <= MAX_ATT;
            state_q       <= ST_EDIT;
          end else begin
            lock_cnt <= lock_cnt - 1'b1;
          end
        end
        default: state_q <= ST_EDIT;
      endcase
    end
  end

endmodule

// File: tb/tb_password_lock_ctrl.sv
// Directed bench: strobes are checked against a scoreboard of expected results
// pushed at each submit; a second instance covers the 6-digit hex configuration.
module tb_password_lock_ctrl;

  localparam int N0 = 4, R0 = 10, PW0 = 14, MAXA = 3, LOCKC = 20;
  localparam int N1 = 6, R1 = 16, PW1 = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic mode0, btn_l0, btn_r0, btn_u0, btn_d0, btn_c0;
  logic [PW0-1:0] ref0;
  logic [4*N0-1:0] digits0;
  logic [1:0] cursor0;
  logic [PW0-1:0] entered0, stored0;
  logic [2:0] state0;
  logic commit0, match0, fail0, locked0;
  logic [3:0] att0;

  logic mode1, btn_l1, btn_r1, btn_u1, btn_d1, btn_c1;
  logic [PW1-1:0] ref1;
  logic [4*N1-1:0] digits1;
  logic [2:0] cursor1;
  logic [PW1-1:0] entered1, stored1;
  logic [2:0] state1;
  logic commit1, match1, fail1, locked1;
  logic [3:0] att1;

  password_lock_ctrl #(.NUM_DIGITS(N0), .RADIX(R0), .PW_WIDTH(PW0),
                       .MAX_ATTEMPTS(MAXA), .LOCK_CYCLES(LOCKC)) dut0 (
    .basys_clk(clk), .reset(reset), .mode(mode0),
    .btn_l(btn_l0), .btn_r(btn_r0), .btn_u(btn_u0), .btn_d(btn_d0), .btn_c(btn_c0),
    .ref_password(ref0), .digits(digits0), .cursor(cursor0),
    .entered_value(entered0), .stored_password(stored0), .state(state0),
    .commit_pulse(commit0), .match_pulse(match0), .fail_pulse(fail0),
    .locked(locked0), .attempts_left(att0));

  password_lock_ctrl #(.NUM_DIGITS(N1), .RADIX(R1), .PW_WIDTH(PW1),
                       .MAX_ATTEMPTS(MAXA), .LOCK_CYCLES(LOCKC)) dut1 (
    .basys_clk(clk), .reset(reset), .mode(mode1),
    .btn_l(btn_l1), .btn_r(btn_r1), .btn_u(btn_u1), .btn_d(btn_d1), .btn_c(btn_c1),
    .ref_password(ref1), .digits(digits1), .cursor(cursor1),
    .entered_value(entered1), .stored_password(stored1), .state(state1),
    .commit_pulse(commit1), .match_pulse(match1), .fail_pulse(fail1),
    .locked(locked1), .attempts_left(att1));

  typedef struct {
    logic [2:0]  strobe;   // {commit, match, fail}
    logic [31:0] entered;
    logic [31:0] stored;
    logic [31:0] attempts;
    logic [31:0] digits;
    int          due;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_due;

  int m_dig[N0];
  int m_cur;
  int m_stored;
  int m_att;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: pops one expected result per observed strobe.
  logic [2:0] mon_s;
  exp_t mon_e;
  always @(negedge clk) begin
    mon_s = {commit0, match0, fail0};
    if (mon_s != 3'b000) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {29'd0, mon_s}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("strobe_kind", {29'd0, mon_s}, {29'd0, mon_e.strobe});
        check("strobe_cycle", cyc, mon_e.due);
        check("entered_value", {18'd0, entered0}, mon_e.entered);
        check("stored_password", {18'd0, stored0}, mon_e.stored);
        check("attempts_left", {28'd0, att0}, mon_e.attempts);
        check("digits_at_result", {16'd0, digits0}, mon_e.digits);
      end
    end
  end

  function automatic logic [31:0] model_digits();
    logic [31:0] v = 0;
    for (int i = 0; i < N0; i++) v = v | (32'(m_dig[i]) << (4 * i));
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N0; i++) m_dig[i] = 0;
    m_cur = 0; m_stored = 0; m_att = MAXA;
  endtask

  // b = {c, u, d, l, r}; submit is handled separately.
  task automatic press0(input logic [4:0] b);
    @(negedge clk);
    {btn_c0, btn_u0, btn_d0, btn_l0, btn_r0} = b;
    if (b[3])      m_dig[m_cur] = (m_dig[m_cur] + 1) % R0;
    else if (b[2]) m_dig[m_cur] = (m_dig[m_cur] + R0 - 1) % R0;
    else if (b[1]) m_cur = (m_cur + 1) % N0;
    else if (b[0]) m_cur = (m_cur + N0 - 1) % N0;
    @(negedge clk);
    {btn_c0, btn_u0, btn_d0, btn_l0, btn_r0} = 5'b0;
  endtask

  task automatic set_code0(input logic [15:0] code);
    for (int p = 0; p < N0; p++) begin
      int tgt = int'(code[4*p +: 4]);
      while (m_cur != p) press0(5'b00010);
      while (m_dig[p] != tgt) press0(5'b01000);
    end
    check("code_entry", {16'd0, digits0}, {16'd0, code});
  endtask

  task automatic submit0(input logic m);
    exp_t e;
    logic [31:0] v = 0;
    for (int i = N0 - 1; i >= 0; i--) v = v * R0 + 32'(m_dig[i]);
    v = v & ((32'd1 << PW0) - 1);
    @(negedge clk);
    mode0 = m;
    btn_c0 = 1'b1;
    e.entered = v;
    e.due = cyc + 1 + N0;
    last_due = e.due;
    if (!m) begin
      e.strobe = 3'b100; m_stored = int'(v); m_att = MAXA;
    end else if (v == 32'(ref0)) begin
      e.strobe = 3'b010; m_att = MAXA;
      for (int i = 0; i < N0; i++) m_dig[i] = 0;
    end else begin
      e.strobe = 3'b001; m_att = m_att - 1;
      for (int i = 0; i < N0; i++) m_dig[i] = 0;
    end
    e.stored = 32'(m_stored);
    e.attempts = 32'(m_att);
    e.digits = model_digits();
    sb.push_back(e);
    @(negedge clk);
    btn_c0 = 1'b0;
    mode0 = ~m;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check("sb_drain", sb.size(), 0);
  endtask

  task automatic check_reset0();
    check("rst_state", {29'd0, state0}, 32'd0);
    check("rst_digits", {16'd0, digits0}, 32'd0);
    check("rst_cursor", {30'd0, cursor0}, 32'd0);
    check("rst_entered", {18'd0, entered0}, 32'd0);
    check("rst_stored", {18'd0, stored0}, 32'd0);
    check("rst_attempts", {28'd0, att0}, MAXA);
    check("rst_pulses", {29'd0, commit0, match0, fail0}, 32'd0);
    check("rst_locked", {31'd0, locked0}, 32'd0);
  endtask

  task automatic press1(input logic u, input logic l);
    @(negedge clk);
    btn_u1 = u; btn_l1 = l;
    @(negedge clk);
    btn_u1 = 1'b0; btn_l1 = 1'b0;
  endtask

  initial begin
    int cnt;
    int c0;
    logic seen;
    reset = 1'b1;
    {btn_c0, btn_u0, btn_d0, btn_l0, btn_r0} = 5'b0;
    {btn_c1, btn_u1, btn_d1, btn_l1, btn_r1} = 5'b0;
    mode0 = 1'b0; mode1 = 1'b0;
    ref0 = 14'd1234; ref1 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset0();

    // Commit 23 in set mode.
    repeat (3) press0(5'b01000);
    press0(5'b00010);
    repeat (2) press0(5'b01000);
    check("digits_23", {16'd0, digits0}, 32'h0023);
    check("cursor_after_l", {30'd0, cursor0}, 32'd1);
    submit0(1'b0);
    drain();
    repeat (2) @(negedge clk);
    check("edit_after_commit", {29'd0, state0}, 32'd0);
    check("digits_kept", {16'd0, digits0}, 32'h0023);

    // Cursor/digit wrap and same-cycle priority.
    press0(5'b00001);
    press0(5'b00001);
    check("cursor_wrap_r", {30'd0, cursor0}, 32'd3);
    press0(5'b00100);
    check("digit_wrap_d", {16'd0, digits0}, 32'h9023);
    press0(5'b01010);
    check("u_over_l_digits", {16'd0, digits0}, 32'h0023);
    check("u_over_l_cursor", {30'd0, cursor0}, 32'd3);
    press0(5'b00010);
    check("cursor_wrap_l", {30'd0, cursor0}, 32'd0);

    // Matching check.
    set_code0(16'h1234);
    submit0(1'b1);
    drain();
    repeat (2) @(negedge clk);
    check("digits_cleared", {16'd0, digits0}, 32'd0);

    // Three wrong checks lead to lockout.
    for (int k = 0; k < 3; k++) begin
      set_code0(16'h0005);
      submit0(1'b1);
      drain();
    end
    for (int i = 0; i < 10 && !locked0; i++) @(negedge clk);
    check("lock_start", cyc, last_due + 1);
    check("att_zero_locked", {28'd0, att0}, 32'd0);
    cnt = 0;
    for (int i = 0; i < 100 && locked0; i++) begin
      cnt++;
      btn_u0 = (i % 3 == 1);
      btn_c0 = (i % 3 == 2);
      btn_l0 = (i % 3 == 2);
      @(negedge clk);
    end
    {btn_c0, btn_u0, btn_l0} = 3'b0;
    m_att = MAXA;
    check("lock_len", cnt, LOCKC);
    check("att_after_lock", {28'd0, att0}, MAXA);
    check("edit_after_lock", {29'd0, state0}, 32'd0);
    check("digits_lock_ignored", {16'd0, digits0}, model_digits());
    check("cursor_lock_ignored", {30'd0, cursor0}, 32'(m_cur));
    repeat (4) @(negedge clk);

    // Reset during the second CONVERT cycle.
    set_code0(16'h0042);
    @(negedge clk);
    mode0 = 1'b0;
    btn_c0 = 1'b1;
    @(negedge clk);
    btn_c0 = 1'b0;
    @(negedge clk);
    check("in_convert", {29'd0, state0}, 32'd1);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset0();
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("no_strobe_after_abort", {29'd0, commit0, match0, fail0}, 32'd0);

    // 6-digit hex instance: code FEDCBA.
    for (int i = 0; i < N1; i++) begin
      repeat (10 + i) press1(1'b1, 1'b0);
      press1(1'b0, 1'b1);
    end
    check("hex_digits", {8'd0, digits1}, 32'h00FEDCBA);
    @(negedge clk);
    btn_c1 = 1'b1;
    c0 = cyc;
    @(negedge clk);
    btn_c1 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (commit1) seen = 1'b1;
      else @(negedge clk);
    end
    check("hex_commit_seen", {31'd0, seen}, 32'd1);
    check("hex_latency", cyc - c0, 1 + N1);
    check("hex_entered", {8'd0, entered1}, 32'h00FEDCBA);
    check("hex_stored", {8'd0, stored1}, 32'h00FEDCBA);
    check("hex_attempts", {28'd0, att1}, MAXA);

    repeat (3) @(negedge clk);
    check("sb_empty_end", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
